// File: rtl/datapath_pkg.sv
// Shared constants for the datapath sequencer: opcode map, instruction field
// position, FSM state encoding and strobe bit positions.
package datapath_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ANDLO = 6'h01;
    localparam logic [5:0] OP_ANDHI = 6'h02;
    localparam logic [5:0] OP_LDLO  = 6'h03;
    localparam logic [5:0] OP_ANDW  = 6'h04;
    localparam logic [5:0] OP_JUMP  = 6'h05;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC1  = 3'd2;
    localparam logic [2:0] S_EXEC2  = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;

    // Bit positions inside the 4-bit strobe vector
    localparam int STB_AN_BOT  = 0;
    localparam int STB_AN_TOP  = 1;
    localparam int STB_IMM_BOT = 2;
    localparam int STB_MUX_PC  = 3;

endpackage

// File: rtl/datapath_decode.sv
// Combinational opcode decoder: legality, first-phase strobe, two-phase and
// jump flags.
module datapath_decode
    import datapath_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       legal_o,
    output logic [3:0] strb_o,
    output logic       two_phase_o,
    output logic       jump_o
);

    always_comb begin
        legal_o     = 1'b1;
        strb_o      = 4'b0000;
        two_phase_o = 1'b0;
        jump_o      = 1'b0;
        case (op_i)
            OP_NOP:   ;
            OP_ANDLO: strb_o[STB_AN_BOT]  = 1'b1;
            OP_ANDHI: strb_o[STB_AN_TOP]  = 1'b1;
            OP_LDLO:  strb_o[STB_IMM_BOT] = 1'b1;
            OP_ANDW: begin
                strb_o[STB_AN_BOT] = 1'b1;
                two_phase_o        = 1'b1;
            end
            OP_JUMP: begin
                strb_o[STB_MUX_PC] = 1'b1;
                jump_o             = 1'b1;
            end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller: accepts one instruction, sequences the DataPath
// strobes, owns the PC and publishes the captured AN result.
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] an_i,
    input  logic [31:0] am_i,
    output logic [31:0] pc_o,
    output logic [15:0] imm_o,
    output logic        an_bot_o,
    output logic        an_top_o,
    output logic        imm_bot_o,
    output logic        mux_pc_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        err_o,
    output logic        busy_o
);

    logic [2:0]  state_q, state_d;
    logic [5:0]  op_q;
    logic [15:0] imm_q;
    logic [31:0] pc_q;
    logic [31:0] npc_q;
    logic [31:0] result_q;
    logic [3:0]  strb_q, strb_d;

    logic        legal, two_phase, jump;
    logic [3:0]  dec_strb;
    logic        accept;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^instr_i[25:16];

    datapath_decode u_decode (
        .op_i        (op_q),
        .legal_o     (legal),
        .strb_o      (dec_strb),
        .two_phase_o (two_phase),
        .jump_o      (jump)
    );

    assign accept = (state_q == S_IDLE) && instr_valid_i;

    // Strobes are registered: the next-cycle strobe is chosen alongside the
    // transition into EXEC1/EXEC2 so it is high exactly in that state.
    always_comb begin
        state_d = state_q;
        strb_d  = 4'b0000;
        case (state_q)
            S_IDLE: if (instr_valid_i) state_d = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_IDLE;
                end else if (dec_strb == 4'b0000) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_EXEC1;
                    strb_d  = dec_strb;
                end
            end
            S_EXEC1: begin
                if (two_phase) begin
                    state_d             = S_EXEC2;
                    strb_d[STB_AN_TOP]  = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_EXEC2: state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            strb_q   <= 4'b0000;
            op_q     <= OP_NOP;
            imm_q    <= 16'h0000;
            pc_q     <= RESET_PC;
            npc_q    <= 32'h0000_0000;
            result_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            if (accept) begin
                op_q  <= instr_i[OP_MSB:OP_LSB];
                imm_q <= instr_i[15:0];
            end
            if (state_q == S_EXEC1 || state_q == S_EXEC2) result_q <= an_i;
            if (state_q == S_EXEC1 && jump) npc_q <= am_i;
            // Illegal opcodes still advance the PC, straight from DECODE
            if (state_q == S_DECODE && !legal) pc_q <= pc_q + PC_STEP;
            if (state_q == S_WRITE) pc_q <= jump ? npc_q : pc_q + PC_STEP;
        end
    end

    assign instr_ready_o  = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = (state_q == S_WRITE);
    assign err_o          = (state_q == S_DECODE) && !legal;
    assign pc_o           = pc_q;
    assign imm_o          = imm_q;
    assign result_o       = result_q;
    assign an_bot_o       = strb_q[STB_AN_BOT];
    assign an_top_o       = strb_q[STB_AN_TOP];
    assign imm_bot_o      = strb_q[STB_IMM_BOT];
    assign mux_pc_o       = strb_q[STB_MUX_PC];

endmodule
